// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
package uart_pkg;

  localparam int unsigned UART_BYTE_W           = 8;
  localparam int unsigned UART_BLOCK_BYTES_DEF  = 16;

  // Block assembler states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HOLD    = 2'd2
  } rx_blk_state_e;

endpackage : uart_pkg

// File: rtl/uart_idle_timer.sv
// Inter-byte idle timer: counts tick pulses until cleared, flags when the limit is reached.
module uart_idle_timer #(
  parameter int unsigned TO_W = 16
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            clear,
  input  logic            tick,
  input  logic [TO_W-1:0] limit,
  output logic            expired
);

  logic [TO_W-1:0] count_q;
  logic [TO_W-1:0] count_d;

  // Next count: clear wins, otherwise count ticks and stick at full scale.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (tick && (count_q != '1)) begin
      count_d = count_q + TO_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A zero limit disables expiry.
  assign expired = (limit != '0) && (count_q >= limit);

endmodule : uart_idle_timer

// File: rtl/uart_rx_block_ctrl.sv
// Assembles received UART bytes into fixed-size blocks, discarding partial blocks on error or timeout.
module uart_rx_block_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned BLOCK_BYTES = UART_BLOCK_BYTES_DEF,
  parameter int unsigned TO_W        = 16
) (
  input  logic                                Clk,
  input  logic                                Rst,
  input  logic                                En,
  input  logic                                baud_clk,
  input  logic [UART_BYTE_W-1:0]              s_axis_tdata,
  input  logic                                s_axis_tvalid,
  output logic                                s_axis_tready,
  input  logic                                rx_frame_error,
  input  logic                                rx_parity_error,
  input  logic                                rx_overrun_error,
  input  logic [TO_W-1:0]                     timeout_ticks,
  output logic [UART_BYTE_W*BLOCK_BYTES-1:0]  m_axis_tdata,
  output logic                                m_axis_tvalid,
  input  logic                                m_axis_tready,
  output logic [$clog2(BLOCK_BYTES+1)-1:0]    byte_idx,
  output logic                                drop_err,
  output logic                                drop_timeout,
  output logic [7:0]                          drop_cnt
);

  localparam int unsigned IDX_W  = $clog2(BLOCK_BYTES + 1);
  localparam int unsigned DATA_W = UART_BYTE_W * BLOCK_BYTES;

  rx_blk_state_e     state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              derr_q, derr_d;
  logic              dto_q, dto_d;
  logic [7:0]        dcnt_q, dcnt_d;

  logic accept;
  logic rx_err;
  logic in_collect;
  logic timer_clear;
  logic timer_expired;
  logic drop_bump;

  // Ready is a direct function of state so a byte can be taken in the same cycle it is offered.
  assign s_axis_tready = En && !Rst && (state_q != ST_HOLD);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign rx_err        = rx_frame_error || rx_parity_error || rx_overrun_error;
  assign in_collect    = (state_q == ST_COLLECT);
  // Timer only runs while a partial block is waiting for its next byte.
  assign timer_clear   = !En || !in_collect || accept || rx_err || timer_expired;

  uart_idle_timer #(
    .TO_W (TO_W)
  ) u_idle_timer (
    .Clk     (Clk),
    .Rst     (Rst),
    .clear   (timer_clear),
    .tick    (baud_clk),
    .limit   (timeout_ticks),
    .expired (timer_expired)
  );

  // Next-state and output computation; error beats byte beats timeout.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    valid_d   = valid_q;
    idx_d     = idx_q;
    derr_d    = 1'b0;
    dto_d     = 1'b0;
    dcnt_d    = dcnt_q;
    drop_bump = 1'b0;

    case (state_q)
      ST_HOLD: begin
        // Held block is immune to enable and receiver errors until taken.
        if (valid_q && m_axis_tready) begin
          valid_d = 1'b0;
          idx_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        if (!En) begin
          idx_d   = '0;
          state_d = ST_IDLE;
        end else if (rx_err) begin
          idx_d     = '0;
          state_d   = ST_IDLE;
          derr_d    = 1'b1;
          drop_bump = 1'b1;
        end else if (accept) begin
          for (int unsigned k = 0; k < BLOCK_BYTES; k++) begin
            if (idx_q == IDX_W'(k)) begin
              data_d[UART_BYTE_W*k +: UART_BYTE_W] = s_axis_tdata;
            end
          end
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(BLOCK_BYTES - 1)) begin
            state_d = ST_HOLD;
            valid_d = 1'b1;
          end else begin
            state_d = ST_COLLECT;
          end
        end else if (in_collect && timer_expired) begin
          idx_d     = '0;
          state_d   = ST_IDLE;
          dto_d     = 1'b1;
          drop_bump = 1'b1;
        end
      end
    endcase

    if (drop_bump && (dcnt_q != 8'hFF)) begin
      dcnt_d = dcnt_q + 8'd1;
    end
  end

  // State and registered outputs.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      derr_q  <= 1'b0;
      dto_q   <= 1'b0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      derr_q  <= derr_d;
      dto_q   <= dto_d;
      dcnt_q  <= dcnt_d;
    end
  end

  assign m_axis_tdata  = data_q;
  assign m_axis_tvalid = valid_q;
  assign byte_idx      = idx_q;
  assign drop_err      = derr_q;
  assign drop_timeout  = dto_q;
  assign drop_cnt      = dcnt_q;

endmodule : uart_rx_block_ctrl

// File: tb/tb_uart_rx_block_ctrl.sv
// Bench for uart_rx_block_ctrl: reference model feeds expected blocks/drops to a scoreboard.
module tb_uart_rx_block_ctrl;

  localparam int BB = 16;
  localparam int DW = 8 * BB;

  logic          Clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          bt = 1'b0;
  logic [7:0]    sd = '0;
  logic          sv = 1'b0;
  logic          fe = 1'b0, pe = 1'b0, oe = 1'b0;
  logic [15:0]   lim = '0;
  logic          mr = 1'b1;

  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic [4:0]    byte_idx;
  logic          drop_err, drop_timeout;
  logic [7:0]    drop_cnt;

  uart_rx_block_ctrl #(.BLOCK_BYTES(BB), .TO_W(16)) dut (
    .Clk              (Clk),
    .Rst              (rst),
    .En               (en),
    .baud_clk         (bt),
    .s_axis_tdata     (sd),
    .s_axis_tvalid    (sv),
    .s_axis_tready    (s_tready),
    .rx_frame_error   (fe),
    .rx_parity_error  (pe),
    .rx_overrun_error (oe),
    .timeout_ticks    (lim),
    .m_axis_tdata     (m_tdata),
    .m_axis_tvalid    (m_tvalid),
    .m_axis_tready    (mr),
    .byte_idx         (byte_idx),
    .drop_err         (drop_err),
    .drop_timeout     (drop_timeout),
    .drop_cnt         (drop_cnt)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int nvec = 0;
  int nfail = 0;

  typedef struct { int due; bit is_err; int cnt; } drop_t;
  typedef struct { int due; logic [DW-1:0] data; } blk_t;
  drop_t dq[$];
  blk_t  bq[$];

  // Reference model: bytes held, whether a full block is waiting, ticks since last byte.
  logic [7:0] mbuf[$];
  bit  holding = 0;
  int  tcnt = 0;
  int  dcnt = 0;
  bit  exp_tready = 0;
  int  exp_idx = 0;

  task automatic push_drop(input bit is_err);
    drop_t d;
    if (dcnt < 255) dcnt++;
    d.due = cyc + 1; d.is_err = is_err; d.cnt = dcnt;
    dq.push_back(d);
    mbuf.delete();
    tcnt = 0;
  endtask

  // Apply the current inputs to the model, then let the clock edge happen.
  task automatic drive();
    bit collecting;
    blk_t b;
    exp_tready = en && !holding;
    exp_idx    = holding ? BB : mbuf.size();
    if (rst) begin
      mbuf.delete(); holding = 0; tcnt = 0; dcnt = 0; bq.delete();
    end else if (holding) begin
      if (mr) begin holding = 0; mbuf.delete(); end
    end else if (!en) begin
      mbuf.delete(); tcnt = 0;
    end else begin
      collecting = (mbuf.size() > 0);
      if (fe || pe || oe) begin
        push_drop(1'b1);
      end else if (sv) begin
        mbuf.push_back(sd);
        tcnt = 0;
        if (mbuf.size() == BB) begin
          holding = 1;
          b.due = cyc + 1;
          b.data = '0;
          foreach (mbuf[i]) b.data[8*i +: 8] = mbuf[i];
          bq.push_back(b);
        end
      end else if (collecting && lim != 0 && tcnt >= int'(lim)) begin
        push_drop(1'b0);
      end else if (collecting && bt) begin
        tcnt++;
      end
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string nm, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic send(input logic [7:0] b);
    sv = 1'b1; sd = b; drive(); sv = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tvalid"}, int'(m_tvalid), 0);
    nvec++;
    if (m_tdata != '0) begin
      nfail++;
      $display("FAIL %s_tdata: got %h expected 0", tag, m_tdata);
    end
    check({tag, "_idx"}, int'(byte_idx), 0);
    check({tag, "_tready"}, int'(s_tready), 0);
    check({tag, "_drop_err"}, int'(drop_err), 0);
    check({tag, "_drop_to"}, int'(drop_timeout), 0);
    check({tag, "_drop_cnt"}, int'(drop_cnt), 0);
  endtask

  // Scoreboard monitor, sampling mid-cycle.
  always @(negedge Clk) begin
    drop_t d;
    if (dq.size() > 0 && dq[0].due == cyc) begin
      d = dq.pop_front();
      nvec++;
      if (drop_err != d.is_err || drop_timeout != !d.is_err || int'(drop_cnt) != d.cnt) begin
        nfail++;
        $display("FAIL drop: got err=%0d to=%0d cnt=%0d expected err=%0d to=%0d cnt=%0d (cyc %0d)",
                 drop_err, drop_timeout, drop_cnt, d.is_err, !d.is_err, d.cnt, cyc);
      end
    end else if (drop_err || drop_timeout) begin
      nvec++; nfail++;
      $display("FAIL drop_spurious: got err=%0d to=%0d expected none (cyc %0d)", drop_err, drop_timeout, cyc);
    end
    if (!rst) begin
      nvec++;
      if (s_tready != exp_tready) begin
        nfail++;
        $display("FAIL s_tready: got %0d expected %0d (cyc %0d)", s_tready, exp_tready, cyc);
      end
      nvec++;
      if (int'(byte_idx) != exp_idx) begin
        nfail++;
        $display("FAIL byte_idx: got %0d expected %0d (cyc %0d)", byte_idx, exp_idx, cyc);
      end
      if (m_tvalid) begin
        nvec++;
        if (bq.size() == 0 || bq[0].due > cyc) begin
          nfail++;
          $display("FAIL tvalid_unexpected: got tvalid=1 expected 0 (cyc %0d)", cyc);
        end else begin
          if (m_tdata != bq[0].data) begin
            nfail++;
            $display("FAIL tdata: got %h expected %h (cyc %0d)", m_tdata, bq[0].data, cyc);
          end
          if (mr) void'(bq.pop_front());
        end
      end else if (bq.size() > 0 && bq[0].due <= cyc) begin
        nvec++; nfail++;
        $display("FAIL tvalid_latency: got tvalid=0 expected 1 (cyc %0d)", cyc);
        void'(bq.pop_front());
      end
    end
  end

  initial begin
    // Reset and reset-state checks, with En high to show ready is still low.
    rst = 1'b1; en = 1'b1; mr = 1'b1;
    idle(3);
    check_reset_outputs("rst0");
    rst = 1'b0;
    idle(2);

    // Straight block of 0x00..0x0F.
    for (int i = 0; i < 16; i++) send(8'(i));
    idle(3);

    // Back-pressure: block held 50 cycles while more bytes are offered.
    mr = 1'b0;
    for (int i = 0; i < 16; i++) send(8'($urandom));
    for (int i = 0; i < 50; i++) begin sv = 1'b1; sd = 8'($urandom); drive(); end
    sv = 1'b0; mr = 1'b1;
    idle(3);

    // Timeout after 5 bytes with a 24-tick limit, then a fresh block.
    lim = 16'd24;
    for (int i = 0; i < 5; i++) send(8'(8'hA0 + i));
    for (int i = 0; i < 24 * 8 + 16; i++) begin bt = (i % 8 == 7); drive(); end
    bt = 1'b0;
    check("timeout_drop_cnt", int'(drop_cnt), 1);
    for (int i = 0; i < 16; i++) send(8'(8'h30 + i));
    idle(3);
    lim = '0;

    // Parity error alongside byte 8.
    for (int i = 0; i < 8; i++) send(8'($urandom));
    pe = 1'b1; send(8'h55); pe = 1'b0;
    check("perr_idx", int'(byte_idx), 0);
    idle(3);

    // Frame error alongside the final byte.
    for (int i = 0; i < 15; i++) send(8'($urandom));
    fe = 1'b1; send(8'hEE); fe = 1'b0;
    check("lasterr_tvalid", int'(m_tvalid), 0);
    check("lasterr_drop_cnt", int'(drop_cnt), 3);
    idle(3);

    // Reset in the middle of a block.
    for (int i = 0; i < 10; i++) send(8'($urandom));
    check("mid_idx", int'(byte_idx), 10);
    rst = 1'b1; drive();
    check_reset_outputs("rst_mid");
    rst = 1'b0; idle(2);

    // Reset while holding a block.
    mr = 1'b0;
    for (int i = 0; i < 16; i++) send(8'($urandom));
    idle(2);
    rst = 1'b1; drive();
    check_reset_outputs("rst_hold");
    rst = 1'b0; mr = 1'b1; idle(2);

    // Saturation: 300 forced drops.
    for (int i = 0; i < 300; i++) begin
      sv = 1'b1; sd = 8'($urandom); oe = 1'b1; drive();
    end
    sv = 1'b0; oe = 1'b0;
    idle(1);
    check("sat_drop_cnt", int'(drop_cnt), 255);
    rst = 1'b1; idle(2); rst = 1'b0; idle(1);

    // Randomised traffic.
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) begin
        case ($urandom_range(0, 3))
          0: lim = 16'd0;
          1: lim = 16'd2;
          2: lim = 16'd5;
          default: lim = 16'd12;
        endcase
      end
      en = ($urandom_range(0, 31) != 0);
      sv = ($urandom_range(0, 2) != 0);
      sd = 8'($urandom);
      fe = ($urandom_range(0, 99) == 0);
      pe = ($urandom_range(0, 99) == 0);
      oe = ($urandom_range(0, 149) == 0);
      mr = ($urandom_range(0, 2) != 0);
      bt = ($urandom_range(0, 3) == 0);
      drive();
    end

    // Drain and confirm everything expected was seen.
    en = 1'b1; sv = 1'b0; fe = 1'b0; pe = 1'b0; oe = 1'b0; mr = 1'b1; bt = 1'b0; lim = '0;
    idle(6);
    @(negedge Clk); #1;
    check("blocks_outstanding", bq.size(), 0);
    check("drops_outstanding", dq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule : tb_uart_rx_block_ctrl

// File: doc/uart_rx_block_ctrl.md
UART_RX_BLOCK_CTRL -- requirements
Module: uart_rx_block_ctrl

Interface
REQ-001 SHALL have parameter BLOCK_BYTES, default 16: bytes per assembled block (2..32).
REQ-002 SHALL have parameter TO_W, default 16: width of the timeout configuration and counter.
REQ-003 SHALL have port Clk  in  1  system clock; reset Rst, synchronous, active-high; clock Clk.
REQ-004 SHALL have port Rst  in  1  synchronous active-high reset.
REQ-005 SHALL have port En  in  1  block enable.
REQ-006 SHALL have port baud_clk  in  1  one-Clk pulse at 8x bit rate.
REQ-007 SHALL have port s_axis_tdata / s_axis_tvalid / s_axis_tready  in/in/out  8/1/1  byte stream from the receiver.
REQ-008 SHALL have port rx_frame_error / rx_parity_error / rx_overrun_error  in  1 each  receiver error pulses.
REQ-009 SHALL have port timeout_ticks  in  TO_W  inter-byte timeout in baud_clk pulses; 0 disables the timeout.
REQ-010 SHALL have port m_axis_tdata / m_axis_tvalid / m_axis_tready  out/out/in  8*BLOCK_BYTES/1/1  assembled block.
REQ-011 SHALL have port byte_idx  out  $clog2(BLOCK_BYTES+1)  number of bytes held in the partial block.
REQ-012 SHALL have port drop_err / drop_timeout  out  1 each  one-cycle pulse on block discard, by cause.
REQ-013 SHALL have port drop_cnt  out  8  saturating count of discarded blocks.

Function
REQ-014 SHALL implement states IDLE, COLLECT and HOLD.
REQ-015 SHALL drive s_axis_tready=1 in IDLE/COLLECT when En=1, and 0 in HOLD or when En=0.
REQ-016 SHALL store byte k at m_axis_tdata[8k+7:8k], with the first byte in lane 0, and increment byte_idx on each accepted byte.
REQ-017 SHALL move IDLE->COLLECT on the first accepted byte.
REQ-018 SHALL move to HOLD on acceptance of byte BLOCK_BYTES-1 and assert m_axis_tvalid on the next Clk edge (1-cycle latency).
REQ-019 SHALL hold m_axis_tdata stable while m_axis_tvalid=1.
REQ-020 SHALL, in HOLD on m_axis_tvalid&&m_axis_tready, clear tvalid, set byte_idx=0 and go to IDLE; the first new byte is accepted no earlier than the following cycle.
REQ-021 SHALL keep a timeout counter that clears on each accepted byte and increments on each baud_clk pulse in COLLECT.
REQ-022 SHALL, when the counter reaches timeout_ticks (nonzero) in COLLECT, discard the partial block, pulse drop_timeout, set byte_idx=0 and go to IDLE.
REQ-023 SHALL, when any rx_*_error pulse occurs in IDLE or COLLECT, discard the partial block, pulse drop_err and go to IDLE; a byte accepted in the same cycle is discarded too.
REQ-024 SHALL, on an error in the same cycle as the final byte, drop the block and not enter HOLD.
REQ-025 SHALL ignore error pulses in HOLD; the held block is delivered unchanged.
REQ-026 SHALL, when timeout expiry and an error coincide, pulse drop_err only and increment drop_cnt once.
REQ-027 SHALL increment drop_cnt on each drop, saturating at 255.
REQ-028 SHALL, on En=0 in IDLE/COLLECT, discard the partial block silently (no drop pulse), clear the counter and go to IDLE.
REQ-029 SHALL, on En=0 in HOLD, keep m_axis_tvalid asserted until the handshake completes.

Reset
REQ-030 SHALL, on Rst, enter IDLE with m_axis_tvalid=0, m_axis_tdata=0, byte_idx=0, s_axis_tready=0, drop_err=0, drop_timeout=0, drop_cnt=0 and timeout counter 0, taking priority over all other inputs including a mid-block or HOLD state.

Structure
REQ-031 SHALL take the state enum and the default BLOCK_BYTES constant from the shared package uart_pkg.
REQ-032 SHALL implement the timeout as sub-module uart_idle_timer (inputs clear, tick, limit; output expired).

Verification
REQ-033 SHALL cover: 16 bytes 0x00..0x0F with m_tready=1 -> one block, tdata=0x0F0E..0100, tvalid 1 cycle after byte 15.
REQ-034 SHALL cover: m_tready=0 for 50 cycles after a block -> tvalid held with data stable, s_tready=0, extra bytes not accepted.
REQ-035 SHALL cover: 5 bytes, then idle with timeout_ticks=24 -> drop_timeout pulse after the 24th baud_clk, drop_cnt=1, then 16 fresh bytes -> correct block.
REQ-036 SHALL cover: rx_parity_error pulsed with byte 8 -> drop_err pulse, byte_idx=0, no block output.
REQ-037 SHALL cover: error pulse coinciding with byte 15 -> no tvalid, drop_cnt increments.
REQ-038 SHALL cover: Rst asserted at byte_idx=10 and in HOLD -> all outputs at reset values next cycle; 300 forced drops -> drop_cnt=255.
